// File: rtl/rmii_transmitter_pkg.sv
// Shared types and constants for the RMII transmit path: FSM states,
// preamble/SFD byte values, CRC-32 constants and an FCS byte selector.
package rmii_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_GAP
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam logic [31:0] CRC_POLYNOMIAL  = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;
    localparam int          DIBITS_PER_BYTE = 4;
    localparam int          PREAMBLE_BYTES  = 7;
    localparam int          BYTE_COUNT_BITS = 11;
    localparam logic [BYTE_COUNT_BITS-1:0] BYTE_COUNT_MAX = '1;

    // FCS byte 'index' as it goes on the wire: the complemented CRC, LSB byte first.
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] index);
        logic [31:0] w_shifted;
        w_shifted = (~crc) >> {index, 3'b000};
        return w_shifted[7:0];
    endfunction

endpackage

// File: rtl/ethernet_crc32_dibit.sv
// Combinational CRC-32 (reflected, 0xEDB88320) advance by one RMII dibit.
// Bit 0 of the dibit is the earlier bit on the wire, so it is folded in first.
// Shared with the receive-side FCS checker.
module ethernet_crc32_dibit
    import rmii_transmitter_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [1:0]  i_dibit,
    output logic [31:0] o_crc
);

    logic [31:0] w_crc;

    // Two serial LFSR steps, LSB-first, unrolled.
    always_comb begin
        w_crc = i_crc;
        for (int i = 0; i < 2; i++) begin
            if (w_crc[0] ^ i_dibit[i]) begin
                w_crc = (w_crc >> 1) ^ CRC_POLYNOMIAL;
            end else begin
                w_crc = w_crc >> 1;
            end
        end
    end

    assign o_crc = w_crc;

endmodule

// File: rtl/rmii_transmitter.sv
// RMII transmit MAC serializer: turns a 9-bit byte stream (bit 8 = last byte)
// into preamble, SFD, payload, zero padding, CRC-32 FCS and interframe gap,
// two bits per 50 MHz reference clock.
module rmii_transmitter
    import rmii_transmitter_pkg::*;
#(
    parameter int MINIMUM_FRAME_BYTES  = 60,
    parameter int INTERFRAME_GAP_BYTES = 12,
    parameter bit APPEND_FCS           = 1'b1
)(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [8:0] transmit_data,
    input  logic       transmit_data_valid,
    output logic       transmit_data_ready,
    output logic [1:0] rmii_transmit_data,
    output logic       rmii_transmit_data_valid,
    output logic       transmit_underrun
);

    localparam int GAP_CYCLES = INTERFRAME_GAP_BYTES * DIBITS_PER_BYTE;
    localparam int GAP_WIDTH  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_WIDTH-1:0] GAP_LAST =
        GAP_WIDTH'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [BYTE_COUNT_BITS-1:0] MIN_BYTES = BYTE_COUNT_BITS'(MINIMUM_FRAME_BYTES);
    // With no gap configured a finished frame drops straight back to IDLE.
    localparam tx_state_t END_STATE = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    tx_state_t                  r_state;
    logic [1:0]                 r_dibit;
    logic [2:0]                 r_sub_count;   // preamble byte index, then FCS byte index
    logic [BYTE_COUNT_BITS-1:0] r_byte_count;  // payload + pad bytes loaded so far
    logic [GAP_WIDTH-1:0]       r_gap_count;
    logic [7:0]                 r_shift;       // [1:0] is the dibit currently on TXD
    logic                       r_last;        // byte in r_shift carried the last flag
    logic                       r_tx_en;
    logic [31:0]                r_crc;

    logic                       w_byte_end;
    logic                       w_ready;
    logic                       w_need_pad;
    logic [7:0]                 w_shift_next;
    logic [7:0]                 w_fcs_next_byte;
    logic [BYTE_COUNT_BITS-1:0] w_byte_count_inc;
    logic [31:0]                w_crc_next;

    // CRC advanced by the dibit that is on the wire this cycle.
    ethernet_crc32_dibit u_crc (
        .i_crc   (r_crc),
        .i_dibit (r_shift[1:0]),
        .o_crc   (w_crc_next)
    );

    assign w_byte_end       = (r_dibit == 2'd3);
    // A new byte is pulled only at the last dibit of SFD or of a non-final data byte.
    assign w_ready          = w_byte_end &&
                              ((r_state == ST_SFD) || ((r_state == ST_DATA) && !r_last));
    assign w_need_pad       = (r_byte_count < MIN_BYTES);
    assign w_shift_next     = {2'b00, r_shift[7:2]};
    assign w_byte_count_inc = (r_byte_count == BYTE_COUNT_MAX) ? r_byte_count
                                                               : r_byte_count + 1'b1;
    assign w_fcs_next_byte  = fcs_byte(r_crc, r_sub_count[1:0] + 2'd1);

    assign transmit_data_ready      = w_ready;
    assign transmit_underrun        = w_ready && !transmit_data_valid;
    assign rmii_transmit_data       = r_shift[1:0];
    assign rmii_transmit_data_valid = r_tx_en;

    // Frame sequencer; TXD/TX_EN come straight from r_shift/r_tx_en.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_dibit      <= '0;
            r_sub_count  <= '0;
            r_byte_count <= '0;
            r_gap_count  <= '0;
            r_shift      <= '0;
            r_last       <= 1'b0;
            r_tx_en      <= 1'b0;
            r_crc        <= CRC_INIT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (transmit_data_valid) begin
                        r_state      <= ST_PREAMBLE;
                        r_tx_en      <= 1'b1;
                        r_shift      <= PREAMBLE_BYTE;
                        r_dibit      <= '0;
                        r_sub_count  <= '0;
                        r_byte_count <= '0;
                        r_last       <= 1'b0;
                        r_crc        <= CRC_INIT;
                    end
                end

                ST_PREAMBLE: begin
                    r_dibit <= r_dibit + 2'd1;
                    if (w_byte_end) begin
                        if (r_sub_count == 3'(PREAMBLE_BYTES - 1)) begin
                            r_state     <= ST_SFD;
                            r_sub_count <= '0;
                            r_shift     <= SFD_BYTE;
                        end else begin
                            r_sub_count <= r_sub_count + 3'd1;
                            r_shift     <= PREAMBLE_BYTE;
                        end
                    end else begin
                        r_shift <= w_shift_next;
                    end
                end

                ST_SFD: begin
                    r_dibit <= r_dibit + 2'd1;
                    r_crc   <= CRC_INIT;
                    if (w_byte_end) begin
                        if (transmit_data_valid) begin
                            r_state      <= ST_DATA;
                            r_shift      <= transmit_data[7:0];
                            r_last       <= transmit_data[8];
                            r_byte_count <= BYTE_COUNT_BITS'(1);
                        end else begin
                            // No first byte: abort the frame after SFD.
                            r_state     <= END_STATE;
                            r_tx_en     <= 1'b0;
                            r_shift     <= '0;
                            r_dibit     <= '0;
                            r_gap_count <= '0;
                            r_last      <= 1'b0;
                        end
                    end else begin
                        r_shift <= w_shift_next;
                    end
                end

                ST_DATA: begin
                    r_dibit <= r_dibit + 2'd1;
                    r_crc   <= w_crc_next;
                    if (w_byte_end) begin
                        if (r_last) begin
                            if (w_need_pad) begin
                                r_state      <= ST_PAD;
                                r_shift      <= '0;
                                r_byte_count <= w_byte_count_inc;
                            end else if (APPEND_FCS) begin
                                r_state     <= ST_FCS;
                                r_sub_count <= '0;
                                r_shift     <= ~w_crc_next[7:0];
                            end else begin
                                r_state     <= END_STATE;
                                r_tx_en     <= 1'b0;
                                r_shift     <= '0;
                                r_dibit     <= '0;
                                r_gap_count <= '0;
                                r_last      <= 1'b0;
                            end
                        end else if (transmit_data_valid) begin
                            r_shift      <= transmit_data[7:0];
                            r_last       <= transmit_data[8];
                            r_byte_count <= w_byte_count_inc;
                        end else begin
                            // Underrun: truncate the frame, no FCS, still enforce the gap.
                            r_state     <= END_STATE;
                            r_tx_en     <= 1'b0;
                            r_shift     <= '0;
                            r_dibit     <= '0;
                            r_gap_count <= '0;
                            r_last      <= 1'b0;
                        end
                    end else begin
                        r_shift <= w_shift_next;
                    end
                end

                ST_PAD: begin
                    r_dibit <= r_dibit + 2'd1;
                    r_crc   <= w_crc_next;
                    if (w_byte_end) begin
                        if (w_need_pad) begin
                            r_shift      <= '0;
                            r_byte_count <= w_byte_count_inc;
                        end else if (APPEND_FCS) begin
                            r_state     <= ST_FCS;
                            r_sub_count <= '0;
                            r_shift     <= ~w_crc_next[7:0];
                        end else begin
                            r_state     <= END_STATE;
                            r_tx_en     <= 1'b0;
                            r_shift     <= '0;
                            r_dibit     <= '0;
                            r_gap_count <= '0;
                            r_last      <= 1'b0;
                        end
                    end else begin
                        r_shift <= w_shift_next;
                    end
                end

                ST_FCS: begin
                    // r_crc holds the final (uncomplemented) CRC for the whole state.
                    r_dibit <= r_dibit + 2'd1;
                    if (w_byte_end) begin
                        if (r_sub_count == 3'd3) begin
                            r_state     <= END_STATE;
                            r_tx_en     <= 1'b0;
                            r_shift     <= '0;
                            r_dibit     <= '0;
                            r_gap_count <= '0;
                            r_last      <= 1'b0;
                        end else begin
                            r_sub_count <= r_sub_count + 3'd1;
                            r_shift     <= w_fcs_next_byte;
                        end
                    end else begin
                        r_shift <= w_shift_next;
                    end
                end

                ST_GAP: begin
                    if (r_gap_count == GAP_LAST) begin
                        r_gap_count <= '0;
                        // Back-to-back: start the next preamble without an idle cycle.
                        if (transmit_data_valid) begin
                            r_state      <= ST_PREAMBLE;
                            r_tx_en      <= 1'b1;
                            r_shift      <= PREAMBLE_BYTE;
                            r_dibit      <= '0;
                            r_sub_count  <= '0;
                            r_byte_count <= '0;
                            r_last       <= 1'b0;
                            r_crc        <= CRC_INIT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_gap_count <= r_gap_count + GAP_WIDTH'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_tx_en <= 1'b0;
                    r_shift <= '0;
                end
            endcase
        end
    end

endmodule
